// File: rtl/t_pulse_debouncer_pkg.sv
// Shared types for the push-button debouncer: FSM state encoding and a level decode helper.
package t_pulse_debouncer_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        PRESSED   = 2'd2,
        RELEASING = 2'd3
    } db_state_t;

    // The debounced level is high while the button is held or while a release is still unconfirmed.
    function automatic logic is_held(input db_state_t s);
        return (s == PRESSED) || (s == RELEASING);
    endfunction

endpackage

// File: rtl/t_pulse_debouncer_sync_2ff.sv
// Two-flop synchroniser for the asynchronous button level; both stages clear to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/t_pulse_debouncer.sv
// Debounces a raw push-button and emits a one-cycle toggle pulse on t per accepted press.
module t_pulse_debouncer
    import t_pulse_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_in,
    output logic             t,
    output logic             btn_stable,
    output logic [CNT_W-1:0] press_count
);

    localparam int unsigned    CW        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  LAST      = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic           ONE_CYCLE = (DEBOUNCE_CYCLES == 1);

    logic          sync2;
    db_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          t_q, pulse_nxt;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (sync2)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            t_q         <= 1'b0;
            press_count <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            t_q   <= pulse_nxt;
            if (pulse_nxt) begin
                press_count <= press_count + CNT_W'(1);
            end
        end
    end

    // With a one-cycle window the first matching sample already confirms, so ARMING/RELEASING are skipped.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pulse_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (sync2) begin
                    if (ONE_CYCLE) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                        pulse_nxt = 1'b1;
                    end else begin
                        state_nxt = ARMING;
                        cnt_nxt   = CW'(1);
                    end
                end
            end
            ARMING: begin
                if (!sync2) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            PRESSED: begin
                if (!sync2) begin
                    if (ONE_CYCLE) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = RELEASING;
                        cnt_nxt   = CW'(1);
                    end
                end
            end
            RELEASING: begin
                if (sync2) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        t          = t_q;
        btn_stable = is_held(state);
    end

endmodule

// File: tb/tb_t_pulse_debouncer.sv
// Directed/randomised bench for t_pulse_debouncer against a sliding-window debounce model.
module tb_t_pulse_debouncer;

    localparam int unsigned N     = 4;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             btn_in = 1'b0;
    logic             t;
    logic             btn_stable;
    logic [CNT_W-1:0] press_count;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic             m_s1, m_s2, m_stable, m_t;
    logic [CNT_W-1:0] m_count;
    logic             win[$];
    logic             tq_dut, tq_ref;

    int edge_idx, pulse_at, pulses, fall_at, seen;

    always #4 clk = ~clk;

    t_pulse_debouncer #(
        .DEBOUNCE_CYCLES (N),
        .CNT_W           (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .t           (t),
        .btn_stable  (btn_stable),
        .press_count (press_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_s1 = 1'b0; m_s2 = 1'b0; m_stable = 1'b0; m_t = 1'b0;
        m_count = '0;
        win.delete();
        tq_dut = 1'b0; tq_ref = 1'b0;
    endtask

    task automatic mark();
        edge_idx = 0; pulse_at = -1; pulses = 0;
    endtask

    // Advance one rising edge with btn_in already driven, update the model, then compare.
    task automatic edge_chk(input logic b);
        logic t_before, v, all_diff;
        t_before = t;
        @(posedge clk);
        if (!rst) begin
            m_reset();
        end else begin
            if (t_before) tq_dut = ~tq_dut;
            if (m_t)      tq_ref = ~tq_ref;
            v    = m_s2;
            m_s2 = m_s1;
            m_s1 = b;
            win.push_back(v);
            if (win.size() > N) void'(win.pop_front());
            m_t = 1'b0;
            all_diff = (win.size() == N);
            foreach (win[i]) if (win[i] == m_stable) all_diff = 1'b0;
            if (all_diff) begin
                m_stable = ~m_stable;
                if (m_stable) begin
                    m_t = 1'b1;
                    m_count = m_count + 1'b1;
                end
            end
        end
        #1;
        check("t",           32'(t),           32'(m_t));
        check("btn_stable",  32'(btn_stable),  32'(m_stable));
        check("press_count", 32'(press_count), 32'(m_count));
        check("tff_q",       32'(tq_dut),      32'(tq_ref));
        if (t) begin
            pulses++;
            if (pulse_at < 0) pulse_at = edge_idx;
        end
        edge_idx++;
    endtask

    task automatic step(input logic b);
        @(negedge clk);
        btn_in = b;
        edge_chk(b);
    endtask

    task automatic hold(input logic b, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(b);
    endtask

    task automatic async_reset(input string tag);
        #1;
        rst = 1'b0;
        m_reset();
        #1;
        check({tag, "_t"},     32'(t),           32'd0);
        check({tag, "_stable"}, 32'(btn_stable), 32'd0);
        check({tag, "_count"}, 32'(press_count), 32'd0);
    endtask

    task automatic release_rst(input logic b);
        @(negedge clk);
        rst = 1'b1;
        btn_in = b;
        edge_chk(b);
    endtask

    task automatic press();
        int unsigned bl;
        if ($urandom_range(0, 1) == 1) begin
            bl = $urandom_range(1, N - 1);
            hold(1'b1, bl);
            hold(1'b0, 1);
        end
        hold(1'b1, $urandom_range(N, N + 3));
        hold(1'b0, $urandom_range(N, N + 3));
    endtask

    initial begin
        m_reset();
        mark();

        // 1: async reset with the button chattering
        #3;
        async_reset("rst_fall");
        for (int i = 0; i < 5; i++) begin
            #2 btn_in = ~btn_in;
            check("rst_hold_t",      32'(t),           32'd0);
            check("rst_hold_stable", 32'(btn_stable),  32'd0);
            check("rst_hold_count",  32'(press_count), 32'd0);
        end
        release_rst(1'b0);
        hold(1'b0, 4);

        // 3: bounces shorter than the window
        mark();
        step(1); step(0); step(1); step(1); step(0); step(1); step(1); step(1); step(0);
        hold(1'b0, 6);
        for (int i = 0; i < 10; i++) begin
            hold(1'b1, $urandom_range(1, N - 1));
            hold(1'b0, $urandom_range(1, 3));
        end
        hold(1'b0, 6);
        check("bounce_pulses", 32'(pulses),      32'd0);
        check("bounce_count",  32'(press_count), 32'd0);
        check("bounce_stable", 32'(btn_stable),  32'd0);

        // 2: clean press held 20 cycles
        mark();
        hold(1'b1, 20);
        check("press_latency", 32'(pulse_at),    32'd5);
        check("press_pulses",  32'(pulses),      32'd1);
        check("press_count",   32'(press_count), 32'd1);
        check("press_stable",  32'(btn_stable),  32'd1);

        // 4: release, then a second press
        mark();
        fall_at = -1;
        for (int i = 0; i < 10; i++) begin
            step(0);
            if (btn_stable === 1'b0 && fall_at < 0) fall_at = i;
        end
        check("release_latency", 32'(fall_at), 32'd5);
        check("release_pulses",  32'(pulses),  32'd0);
        hold(1'b1, 10);
        hold(1'b0, 10);
        check("second_count", 32'(press_count), 32'd2);

        // 5: wrap of the press counter
        async_reset("wrap_rst");
        release_rst(1'b0);
        hold(1'b0, 3);
        mark();
        for (int i = 0; i < 255; i++) press();
        check("wrap_255", 32'(press_count), 32'd255);
        press();
        check("wrap_0",      32'(press_count), 32'd0);
        check("wrap_pulses", 32'(pulses),      32'd256);

        // 6: reset while arming, button still held at release
        press();
        check("pre6_count", 32'(press_count), 32'd1);
        hold(1'b1, 4);
        check("arming_stable", 32'(btn_stable), 32'd0);
        async_reset("arming_rst");
        #10;
        check("arming_hold_count", 32'(press_count), 32'd0);
        mark();
        release_rst(1'b1);
        hold(1'b1, 9);
        check("rearm_latency", 32'(pulse_at),    32'd5);
        check("rearm_pulses",  32'(pulses),      32'd1);
        check("rearm_count",   32'(press_count), 32'd1);
        hold(1'b0, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
